// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - operand-stack RAM sequencer with push/pop/peek and occupancy flags.
// Optional underflow/overflow guard enabled by defining STACK_CTRL_GUARD_EN.
module stack_ctrl #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Push,
  input  logic          Pop,
  input  logic          tos,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          done,
  output logic          busy,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          err,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

`ifdef STACK_CTRL_GUARD_EN
  localparam bit GuardEn = 1'b1;
`else
  localparam bit GuardEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WR, RD, CAP} state_t;

  state_t        state_q, state_d;
  logic [AW:0]   sp_q, sp_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          pop_q, pop_d;
  logic [AW:0]   sp_m1;

  assign sp_m1 = sp_q - (AW+1)'(1);
  assign empty = (sp_q == '0);
  assign full  = (sp_q == (AW+1)'(1 << AW));

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    dout_d  = dout_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = err_q;
    pop_d   = pop_q;
    case (state_q)
      IDLE: begin
        if (Push) begin
          if (GuardEn && full) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = WR;
            wdata_d = din;
          end
        end else if (Pop || tos) begin
          if (GuardEn && empty) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = RD;
            pop_d   = Pop;
          end
        end
      end
      WR: begin
        sp_d    = sp_q + (AW+1)'(1);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      RD: state_d = CAP;
      CAP: begin
        // ram_rdata reflects the address presented during RD
        dout_d  = ram_rdata;
        if (pop_q) sp_d = sp_m1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sp_q    <= '0;
      dout_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      dout_q  <= dout_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pop_q   <= pop_d;
    end
  end

  assign dout      = dout_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign count     = sp_q;
  assign err       = err_q;
  assign ram_wdata = wdata_q;
  assign ram_we    = (state_q == WR) && !rst;
  assign ram_addr  = rst ? '0 : ((state_q == WR) ? sp_q[AW-1:0] : sp_m1[AW-1:0]);

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - directed self-checking bench for stack_ctrl (AW=2, depth 4).
module tb_stack_ctrl;
  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          Push = 1'b0, Pop = 1'b0, tos = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          done, busy, empty, full, err, ram_we;
  logic [AW:0]   count;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] mem [4];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  stack_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .Push(Push), .Pop(Pop), .tos(tos), .din(din),
    .dout(dout), .done(done), .busy(busy), .empty(empty), .full(full),
    .count(count), .err(err), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
    vectors++; if ({empty, full, busy, done, err, ram_we} !== 6'b100000) begin miscompares++; $display("FAIL reset_flags got %b exp 100000", {empty, full, busy, done, err, ram_we}); end
    vectors++; if (dout !== 8'h00 || ram_addr !== 2'd0 || ram_wdata !== 8'h00) begin miscompares++; $display("FAIL reset_data dout=%h addr=%0d wdata=%h exp 0", dout, ram_addr, ram_wdata); end
    rst = 1'b0;
  endtask

  task automatic test_push(input logic [7:0] d, input logic [1:0] addr, input logic [2:0] cnt_after);
    @(negedge clk); Push = 1'b1; din = d;
    @(negedge clk); Push = 1'b0;
    vectors++; if ({busy, ram_we, done} !== 3'b110 || ram_addr !== addr || ram_wdata !== d) begin miscompares++; $display("FAIL push_wr busy/we/done=%b addr=%0d wdata=%h exp 110 %0d %h", {busy, ram_we, done}, ram_addr, ram_wdata, addr, d); end
    @(negedge clk);
    vectors++; if ({busy, ram_we, done} !== 3'b001 || count !== cnt_after) begin miscompares++; $display("FAIL push_done busy/we/done=%b count=%0d exp 001 %0d", {busy, ram_we, done}, count, cnt_after); end
  endtask

  task automatic test_pop(input logic is_pop, input logic [1:0] addr, input logic [7:0] exp_d, input logic [2:0] cnt_after);
    @(negedge clk); Pop = is_pop; tos = ~is_pop;
    @(negedge clk); Pop = 1'b0; tos = 1'b0;
    vectors++; if ({busy, ram_we, done} !== 3'b100 || ram_addr !== addr) begin miscompares++; $display("FAIL pop_rd busy/we/done=%b addr=%0d exp 100 %0d", {busy, ram_we, done}, ram_addr, addr); end
    @(negedge clk);
    vectors++; if ({busy, ram_we, done} !== 3'b100 || ram_addr !== addr) begin miscompares++; $display("FAIL pop_cap busy/we/done=%b addr=%0d exp 100 %0d", {busy, ram_we, done}, ram_addr, addr); end
    @(negedge clk);
    vectors++; if (done !== 1'b1 || busy !== 1'b0 || dout !== exp_d || count !== cnt_after) begin miscompares++; $display("FAIL pop_done done=%b busy=%b dout=%h count=%0d exp 1 0 %h %0d", done, busy, dout, count, exp_d, cnt_after); end
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL done_width got %b exp 0", done); end
  endtask

  task automatic test_priority();
    test_push(8'h44, 2'd0, 3'd1);
    @(negedge clk); Push = 1'b1; Pop = 1'b1; tos = 1'b1; din = 8'h55;
    @(negedge clk); Push = 1'b0; Pop = 1'b0; tos = 1'b0;
    vectors++; if (ram_we !== 1'b1 || ram_addr !== 2'd1 || ram_wdata !== 8'h55) begin miscompares++; $display("FAIL prio_wr we=%b addr=%0d wdata=%h exp 1 1 55", ram_we, ram_addr, ram_wdata); end
    @(negedge clk);
    vectors++; if (done !== 1'b1 || count !== 3'd2 || dout !== 8'h11) begin miscompares++; $display("FAIL prio_done done=%b count=%0d dout=%h exp 1 2 11", done, count, dout); end
  endtask

  task automatic test_busy_ignore();
    @(negedge clk); Pop = 1'b1;
    @(negedge clk); Pop = 1'b0; Push = 1'b1; din = 8'h66;
    vectors++; if (ram_we !== 1'b0 || ram_addr !== 2'd1) begin miscompares++; $display("FAIL busy_rd we=%b addr=%0d exp 0 1", ram_we, ram_addr); end
    @(negedge clk); Push = 1'b0;
    vectors++; if (ram_we !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL busy_cap we=%b busy=%b exp 0 1", ram_we, busy); end
    @(negedge clk);
    vectors++; if (done !== 1'b1 || dout !== 8'h55 || count !== 3'd1) begin miscompares++; $display("FAIL busy_done done=%b dout=%h count=%0d exp 1 55 1", done, dout, count); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || count !== 3'd1) begin miscompares++; $display("FAIL busy_after busy=%b count=%0d exp 0 1", busy, count); end
    test_pop(1'b1, 2'd0, 8'h44, 3'd0);
  endtask

  task automatic test_fill();
    test_push(8'ha0, 2'd0, 3'd1);
    test_push(8'ha1, 2'd1, 3'd2);
    test_push(8'ha2, 2'd2, 3'd3);
    test_push(8'ha3, 2'd3, 3'd4);
    vectors++; if (full !== 1'b1 || empty !== 1'b0) begin miscompares++; $display("FAIL fill_full full=%b empty=%b exp 1 0", full, empty); end
  endtask

`ifdef STACK_CTRL_GUARD_EN
  task automatic test_guard();
    test_fill();
    @(negedge clk); Push = 1'b1; din = 8'hee;
    @(negedge clk); Push = 1'b0;
    vectors++; if ({done, busy, ram_we, err} !== 4'b1001 || count !== 3'd4) begin miscompares++; $display("FAIL guard_full done/busy/we/err=%b count=%0d exp 1001 4", {done, busy, ram_we, err}, count); end
    test_pop(1'b1, 2'd3, 8'ha3, 3'd3);
    test_pop(1'b1, 2'd2, 8'ha2, 3'd2);
    test_pop(1'b1, 2'd1, 8'ha1, 3'd1);
    test_pop(1'b1, 2'd0, 8'ha0, 3'd0);
    test_reset();
    @(negedge clk); Pop = 1'b1;
    @(negedge clk); Pop = 1'b0;
    vectors++; if ({done, busy, err} !== 3'b101 || count !== 3'd0 || dout !== 8'h00) begin miscompares++; $display("FAIL guard_empty done/busy/err=%b count=%0d dout=%h exp 101 0 00", {done, busy, err}, count, dout); end
    @(negedge clk);
    vectors++; if (err !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL guard_sticky err=%b done=%b exp 1 0", err, done); end
  endtask
`else
  task automatic test_wrap();
    test_fill();
    test_push(8'ha4, 2'd0, 3'd5);
    vectors++; if (full !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL wrap_flags full=%b err=%b exp 0 0", full, err); end
    test_pop(1'b1, 2'd0, 8'ha4, 3'd4);
    test_reset();
    test_pop(1'b0, 2'd3, 8'ha3, 3'd0);
    test_pop(1'b1, 2'd3, 8'ha3, 3'd7);
    vectors++; if (err !== 1'b0 || empty !== 1'b0) begin miscompares++; $display("FAIL wrap_under err=%b empty=%b exp 0 0", err, empty); end
  endtask
`endif

  task automatic test_reset_in_wr();
    test_reset();
    test_push(8'h77, 2'd0, 3'd1);
    @(negedge clk); Push = 1'b1; din = 8'h88;
    @(negedge clk); Push = 1'b0;
    vectors++; if (ram_we !== 1'b1) begin miscompares++; $display("FAIL rst_wr_pre we=%b exp 1", ram_we); end
    #1 rst = 1'b1;
    #1;
    vectors++; if (ram_we !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_wr_drop we=%b busy=%b exp 0 0", ram_we, busy); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    vectors++; if (count !== 3'd0 || err !== 1'b0 || done !== 1'b0 || empty !== 1'b1) begin miscompares++; $display("FAIL rst_wr_after count=%0d err=%b done=%b empty=%b exp 0 0 0 1", count, err, done, empty); end
  endtask

  initial begin
    test_reset();
    test_push(8'h11, 2'd0, 3'd1);
    test_push(8'h22, 2'd1, 3'd2);
    test_push(8'h33, 2'd2, 3'd3);
    test_pop(1'b0, 2'd2, 8'h33, 3'd3);
    test_pop(1'b1, 2'd2, 8'h33, 3'd2);
    test_pop(1'b1, 2'd1, 8'h22, 3'd1);
    test_pop(1'b1, 2'd0, 8'h11, 3'd0);
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL end_empty got %b exp 1", empty); end
    test_priority();
    test_busy_ignore();
`ifdef STACK_CTRL_GUARD_EN
    test_guard();
`else
    test_wrap();
`endif
    test_reset_in_wr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Sequencer for the operand-stack RAM of the multicycle stack machine.
- Accepts one-cycle Push/Pop/tos commands from the control unit. Owns the stack pointer and drives a synchronous single-port stack RAM.
- Returns popped or peeked data with a done pulse, and reports occupancy (empty/full/count).

Parameters:
DW, 8, data word width
AW, 5, RAM address width; stack depth = 2^AW

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
Push  input  1  push din onto stack; sampled only when busy=0
Pop  input  1  pop top of stack into dout; sampled only when busy=0
tos  input  1  read top of stack into dout without popping; sampled only when busy=0
din  input  DW  push data; latched on command acceptance
dout  output  DW  registered result of last Pop/tos
done  output  1  one-cycle completion pulse
busy  output  1  high while a command is in flight
empty  output  1  count==0
full  output  1  count==2^AW
count  output  AW+1  current occupancy (= sp)
err  output  1  sticky guard-violation flag
ram_addr  output  AW  stack RAM address
ram_we  output  1  stack RAM write enable
ram_wdata  output  DW  stack RAM write data
ram_rdata  input  DW  stack RAM read data, valid one cycle after ram_addr

Behaviour:
- Clocking and reset: single clock domain, clk. rst is asynchronous and active-high. While rst is high:
  - state=IDLE, sp=0, dout=0, done=0, err=0, busy=0, ram_we=0, ram_wdata=0, ram_addr=0.
  - RAM contents are not touched. An in-flight command is abandoned, and ram_we drops immediately.
- Stack pointer: sp (AW+1 bits) points to the next free slot. count=sp. empty/full are combinational from sp.
- States: IDLE, WR, RD, CAP.
- Acceptance: a command is accepted at a rising edge where state=IDLE and any command bit is high.
  - Priority: Push > Pop > tos. Lower-priority bits asserted in the same cycle are dropped.
  - Accepting a command in the cycle done is high is legal.
- busy = (state != IDLE).
- Push:
  - IDLE -> WR; din is latched into ram_wdata.
  - In WR: ram_we=1, ram_addr=sp[AW-1:0].
  - Edge ending WR: sp<=sp+1, done<=1, state -> IDLE.
  - Latency: done is high in the 2nd cycle after acceptance.
- Pop:
  - IDLE -> RD: ram_addr=(sp-1)[AW-1:0].
  - RD -> CAP: ram_addr is held; ram_rdata is valid.
  - Edge ending CAP: dout<=ram_rdata, sp<=sp-1, done<=1, state -> IDLE.
  - Latency: done and the new dout appear in the 3rd cycle after acceptance.
- tos: identical to Pop, except sp is unchanged.
- ram_we=0 in every state except WR. ram_addr outside WR/RD/CAP = (sp-1)[AW-1:0].
- done is a registered pulse, exactly one cycle wide. dout holds its value until the next Pop/tos completes.
- Commands arriving while busy=1 are ignored. There is no queueing; the control unit must hold off.

Optional Feature:
Macro STACK_CTRL_GUARD_EN.
- Defined:
  - Push when full=1, or Pop/tos when empty=1, is rejected in IDLE: no RAM access, sp and dout unchanged.
  - err<=1 (sticky until rst). done pulses on the next cycle (1-cycle latency). State stays IDLE.
- Undefined:
  - No checks. sp wraps modulo 2^(AW+1). RAM address uses the low AW bits.
  - Push at full overwrites slot 0. Pop at empty reads slot 2^AW-1, and sp becomes all-ones.
  - err is tied to 0.

Test Plan:
- Reset, then Push 0x11, 0x22, 0x33 (each after done):
  - ram_we pulses at addresses 0, 1, 2 with matching data. count=3, done pulses 3 times, busy high 1 cycle each.
- tos after that:
  - ram_addr=2 for 2 cycles, dout=0x33 with done in the 3rd cycle, count stays 3.
- Pop×3:
  - dout=0x33, then 0x22, then 0x11. count goes 2, 1, 0. empty=1 at end.
- Push+Pop+tos asserted together in IDLE with count=1:
  - Push wins, count=2, no read access.
- Push while busy (during RD of a Pop):
  - ignored. Pop completes normally, count decremented by 1 only.
- GUARD_EN, AW=2:
  - 4 pushes set full=1. A 5th push sets err=1, done after 1 cycle, no ram_we, count=4.
  - A Pop on empty also sets err.
  - Assert rst during WR: ram_we drops immediately, and count=0, err=0 after release.
